da_spi_sched: RTL and testbench
===============================

# da_spi_sched

Round-robin scheduler that shares the single 16-bit SPI DAC writer between `NREQ` requesters, such as the ramp generator, the modulation generator and the bias or offset registers. It sits directly upstream of the DAC writer and drives that writer's `da_start` and `da_data` inputs. It spaces writer starts exactly `FRAME_CYCLES` clocks apart so each 16-bit frame (start, 16 data bits, stop) completes before the next start.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `FRAME_CYCLES`, 20: clk_spi cycles between consecutive `da_start` pulses; must be ≥19.
- `CW`, localparam = clog2(`NREQ`): grant index width.

- `clk_spi`, in, 1: clock; the same clock as the DAC writer.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `sched_en`, in, 1: permits new grants.
- `req`, in, `NREQ`: per-requester word pending, level.
- `req_data`, in, 16*`NREQ`: requester i's word is `req_data[16i+15:16i]`.
- `ack`, out, `NREQ`: one-cycle pulse; the word of requester i was captured.
- `da_start`, out, 1: one-cycle start pulse to the DAC writer.
- `da_data`, out, 16: word to the DAC writer; held stable from capture until the next capture.
- `grant_id`, out, `CW`: index of the last granted requester.
- `busy`, out, 1: high whenever state ≠ IDLE.

## Operation
- States: IDLE, START, WAIT. All outputs are registered.
- IDLE:
  - If `sched_en` and `|req`, select winner w.
  - Capture `da_data <= req_data[w]`, `grant_id <= w`, pulse `ack[w]`, then go to START.
  - Otherwise stay in IDLE.
- START: assert `da_start` for exactly this cycle, load `cnt <= FRAME_CYCLES-2`, then go to WAIT.
- WAIT: decrement `cnt`. When `cnt == 0`, do one of the following:
  - If `sched_en` and `|req`: capture, ack and grant exactly as in IDLE, then go to START (back-to-back).
  - Else: go to IDLE.
- Winner selection: round-robin. Search starts at `rr_ptr+1`, wraps modulo `NREQ`, and takes the first asserted `req`. `rr_ptr <= w` on each grant.
- Requester rule:
  - Hold `req` and `req_data` stable until `ack`.
  - Keeping `req` high after `ack` requests a further word; new data must be valid on the cycle after `ack`.
- `req` dropped before `ack`: the request is silently withdrawn; no `ack` is issued.
- `sched_en` low: no new grant. A frame in START or WAIT always runs to completion.
- `cnt` is a clog2(`FRAME_CYCLES`)-bit down-counter. It never underflows and is loaded only in START.
- Reset, including mid-frame: state IDLE, `da_start` 0, `da_data` 0, `ack` 0, `grant_id` 0, `busy` 0, `cnt` 0, `rr_ptr` `NREQ`-1 (first grant favours requester 0). The DAC writer shares `rst_n`, so no partial frame survives reset.

## Timing
- Capture cycle t: `ack` high, `da_data` and `grant_id` updated.
- Cycle t+1: `da_start` high.
- Cycles t+2..t+`FRAME_CYCLES`: WAIT, `FRAME_CYCLES`-1 cycles.
- The next capture occurs at t+`FRAME_CYCLES` at the earliest, giving the next `da_start` at t+1+`FRAME_CYCLES`.
- Continuous requests: `da_start` period is exactly `FRAME_CYCLES`.
- Request latency from IDLE: `req` rising at posedge k produces `ack` during cycle k and `da_start` during cycle k+1.
- `da_data` is stable for ≥`FRAME_CYCLES` cycles around each `da_start`. The writer latches it on the cycle after `da_start`.
- `busy` rises with the capture-to-START transition and falls on entering IDLE.

## Configuration
- `DA_SCHED_RR_EN` defined: round-robin selection as specified above, with `rr_ptr` implemented.
- `DA_SCHED_RR_EN` undefined: fixed priority (lowest asserted index wins). `rr_ptr` is removed; all timing is unchanged.

## Test plan
- Reset with `rst_n`=0 and random inputs: `ack` 0, `da_start` 0, `da_data` 0x0000, `grant_id` 0, `busy` 0.
- Only `req[2]` with 0xA5C3, `sched_en`=1:
  - `ack[2]` is a single pulse, and `da_start` pulses the next cycle.
  - `da_data`=0xA5C3 and `grant_id`=2.
  - `busy` stays high for 20 cycles.
  - The writer's `dout` shifts 0xA5C3 MSB-first with `cs_n` low for 16 sclk.
- All four `req` held, `DA_SCHED_RR_EN` defined: `grant_id` sequence 0,1,2,3,0, `da_start` pulses exactly 20 cycles apart, one `ack` per frame.
- Same stimulus, `DA_SCHED_RR_EN` undefined: `grant_id` sequence 0,0,0, with `ack[0]` every 20 cycles.
- `sched_en` dropped during WAIT with requests pending: the current frame completes, no further `ack` or `da_start` occurs, and `busy` falls at frame end. Re-raising `sched_en` grants within 1 cycle.
- `rst_n` pulsed low mid-WAIT with `rr_ptr`=1: outputs reset asynchronously, and after release with all `req` high the first grant is 0.

Source files
------------

// File: rtl/da_spi_sched.sv
// da_spi_sched: shares one SPI DAC writer between NREQ requesters, one frame per FRAME_CYCLES clocks.
// Define DA_SCHED_RR_EN for round-robin arbitration; otherwise the lowest asserted index wins.
module da_spi_sched #(
  parameter int  NREQ         = 4,
  parameter int  FRAME_CYCLES = 20,
  localparam int CW           = $clog2(NREQ)
) (
  input  logic               clk_spi,
  input  logic               rst_n,
  input  logic               sched_en,
  input  logic [NREQ-1:0]    req,
  input  logic [16*NREQ-1:0] req_data,
  output logic [NREQ-1:0]    ack,
  output logic               da_start,
  output logic [15:0]        da_data,
  output logic [CW-1:0]      grant_id,
  output logic               busy
);
  localparam int TW = $clog2(FRAME_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] cnt, cnt_nxt;
  logic          grant;
  logic [CW-1:0] win;

`ifdef DA_SCHED_RR_EN
  logic [CW-1:0] rr_ptr;

  // Search starts just past the last winner and wraps modulo NREQ.
  always_comb begin : win_sel
    logic found;
    found = 1'b0;
    win   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && req[CW'((int'(rr_ptr) + i) % NREQ)]) begin
        win   = CW'((int'(rr_ptr) + i) % NREQ);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_spi or negedge rst_n) begin
    if (!rst_n)     rr_ptr <= CW'(NREQ - 1);
    else if (grant) rr_ptr <= win;
  end
`else
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[CW'(i)]) win = CW'(i);
  end
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    grant     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sched_en && |req) begin
          grant     = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        cnt_nxt   = TW'(FRAME_CYCLES - 2);
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // Hitting zero here lands the next capture exactly FRAME_CYCLES after the last one.
        if (cnt == '0) begin
          if (sched_en && |req) begin
            grant     = 1'b1;
            state_nxt = ST_START;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_spi or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ack      <= '0;
      da_start <= 1'b0;
      da_data  <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      da_start <= (state == ST_START);
      busy     <= (state_nxt != ST_IDLE);
      ack      <= '0;
      if (grant) begin
        ack[win] <= 1'b1;
        da_data  <= req_data[16*win +: 16];
        grant_id <= win;
      end
    end
  end
endmodule

// File: tb/tb_da_spi_sched.sv
// Randomized bench for da_spi_sched against a frame-timing reference model.
module tb_da_spi_sched;
  localparam int NREQ = 4;
  localparam int F    = 20;

  logic               clk_spi  = 1'b0;
  logic               rst_n    = 1'b0;
  logic               sched_en = 1'b0;
  logic [NREQ-1:0]    req      = '0;
  logic [16*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]    ack;
  logic               da_start;
  logic [15:0]        da_data;
  logic [1:0]         grant_id;
  logic               busy;

  int nvec = 0;
  int nerr = 0;

  da_spi_sched #(.NREQ(NREQ), .FRAME_CYCLES(F)) dut (
    .clk_spi(clk_spi), .rst_n(rst_n), .sched_en(sched_en), .req(req), .req_data(req_data),
    .ack(ack), .da_start(da_start), .da_data(da_data), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk_spi = ~clk_spi;

  // Reference: a grant may happen on any edge at least F cycles after the previous one,
  // start follows one cycle after the ack, busy covers the F cycles from each ack.
  int              cyc      = 0;
  int              last_ack = -1000;
  int              last_w   = NREQ - 1;
  logic [NREQ-1:0] exp_ack  = '0;
  logic            exp_st   = 1'b0;
  logic [15:0]     exp_data = '0;
  logic [1:0]      exp_gid  = '0;
  logic            exp_busy = 1'b0;

  initial forever begin
    @(posedge clk_spi);
    #1;
    if (!rst_n) begin
      cyc = 0; last_ack = -1000; last_w = NREQ - 1;
      exp_ack = '0; exp_st = 1'b0; exp_data = '0; exp_gid = '0; exp_busy = 1'b0;
    end else begin
      int w;
      cyc++;
      exp_ack = '0;
      if (sched_en && |req && (cyc - last_ack) >= F) begin
        w = -1;
`ifdef DA_SCHED_RR_EN
        for (int k = 1; k <= NREQ; k++)
          if (w < 0 && req[2'((last_w + k) % NREQ)]) w = (last_w + k) % NREQ;
`else
        for (int k = NREQ - 1; k >= 0; k--)
          if (req[2'(k)]) w = k;
`endif
        exp_ack[2'(w)] = 1'b1;
        exp_data       = req_data[16*w +: 16];
        exp_gid        = 2'(w);
        last_w         = w;
        last_ack       = cyc;
      end
      exp_st   = (last_ack == cyc - 1);
      exp_busy = ((cyc - last_ack) < F);
    end
  end

  task automatic reset_pulse();
    rst_n = 1'b0; req = '0;
    @(negedge clk_spi);
    @(negedge clk_spi);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sched_en = 1'($urandom);
    req = 4'($urandom);
    req_data = {$urandom, $urandom};
    repeat (3) @(negedge clk_spi);
    nvec++;
    if ({ack, da_start, da_data, grant_id, busy} !== 24'h0) begin
      nerr++;
      $display("FAIL reset: ack=%b st=%b data=%h gid=%0d busy=%b, want all zero", ack, da_start, da_data, grant_id, busy);
    end
    req = '0; sched_en = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int nack = 0, nst = 0, nbusy = 0, tack = -1, tst = -1;
    for (int i = 0; i < NREQ; i++) req_data[16*i +: 16] = 16'($urandom);
    req_data[47:32] = 16'hA5C3;
    req = 4'b0100; sched_en = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_spi);
      nvec++;
      if ({ack, da_start, da_data, grant_id, busy} !== {exp_ack, exp_st, exp_data, exp_gid, exp_busy}) begin
        nerr++;
        $display("FAIL single cyc %0d: {ack,st,data,gid,busy} got %h want %h", cyc,
                 {ack, da_start, da_data, grant_id, busy}, {exp_ack, exp_st, exp_data, exp_gid, exp_busy});
      end
      if (ack != '0) begin
        nack++; tack = c; nvec++;
        if ({ack, da_data, grant_id} !== {4'b0100, 16'hA5C3, 2'd2}) begin
          nerr++;
          $display("FAIL single_grant: ack=%b data=%h gid=%0d, want 0100 a5c3 2", ack, da_data, grant_id);
        end
        req = '0;
      end
      if (da_start) begin nst++; tst = c; end
      if (busy) nbusy++;
    end
    nvec++;
    if (nack != 1 || nst != 1 || tst != tack + 1 || nbusy != F) begin
      nerr++;
      $display("FAIL single_shape: acks=%0d starts=%0d ack@%0d start@%0d busy=%0d, want 1 1 start=ack+1 busy=%0d",
               nack, nst, tack, tst, nbusy, F);
    end
  endtask

  task automatic test_rr_all();
    int gids[$];
    int prev = -1;
`ifdef DA_SCHED_RR_EN
    int want[5] = '{0, 1, 2, 3, 0};
`else
    int want[5] = '{0, 0, 0, 0, 0};
`endif
    reset_pulse();
    for (int i = 0; i < NREQ; i++) req_data[16*i +: 16] = 16'($urandom);
    req = '1; sched_en = 1'b1;
    for (int c = 0; c < 5*F - 1; c++) begin
      @(negedge clk_spi);
      nvec++;
      if ({ack, da_start, da_data, grant_id, busy} !== {exp_ack, exp_st, exp_data, exp_gid, exp_busy}) begin
        nerr++;
        $display("FAIL all_req cyc %0d: {ack,st,data,gid,busy} got %h want %h", cyc,
                 {ack, da_start, da_data, grant_id, busy}, {exp_ack, exp_st, exp_data, exp_gid, exp_busy});
      end
      if (ack != '0) begin
        gids.push_back(int'(grant_id));
        req_data[16*grant_id +: 16] = 16'($urandom);
      end
      if (da_start) begin
        if (prev >= 0) begin
          nvec++;
          if (c - prev != F) begin
            nerr++;
            $display("FAIL start_period: got %0d want %0d", c - prev, F);
          end
        end
        prev = c;
      end
    end
    nvec++;
    if (gids.size() != 5) begin
      nerr++;
      $display("FAIL grant_count: got %0d want 5", gids.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        nvec++;
        if (gids[i] != want[i]) begin
          nerr++;
          $display("FAIL grant_seq[%0d]: got %0d want %0d", i, gids[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_sched_en();
    int seen = 0, extra = 0;
    req = '1; sched_en = 1'b1;
    for (int c = 0; c < 2*F && seen == 0; c++) begin
      @(negedge clk_spi);
      if (ack != '0) seen = 1;
    end
    nvec++;
    if (seen == 0) begin
      nerr++;
      $display("FAIL en_wait_ack: no ack within %0d cycles", 2*F);
    end
    repeat (5) @(negedge clk_spi);
    sched_en = 1'b0;
    for (int c = 0; c < 2*F; c++) begin
      @(negedge clk_spi);
      nvec++;
      if ({ack, da_start, da_data, grant_id, busy} !== {exp_ack, exp_st, exp_data, exp_gid, exp_busy}) begin
        nerr++;
        $display("FAIL en_low cyc %0d: {ack,st,data,gid,busy} got %h want %h", cyc,
                 {ack, da_start, da_data, grant_id, busy}, {exp_ack, exp_st, exp_data, exp_gid, exp_busy});
      end
      if (ack != '0 || da_start) extra++;
    end
    nvec++;
    if (extra != 0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL en_low_quiet: extra ack/start=%0d busy=%b, want 0 0", extra, busy);
    end
    sched_en = 1'b1;
    @(negedge clk_spi);
    nvec++;
    if (ack === '0 || ack !== exp_ack) begin
      nerr++;
      $display("FAIL en_regrant: ack=%b want %b (nonzero)", ack, exp_ack);
    end
  endtask

  task automatic test_reset_mid();
    int nack = 0;
    reset_pulse();
    for (int i = 0; i < NREQ; i++) req_data[16*i +: 16] = 16'($urandom);
    req = '1; sched_en = 1'b1;
    for (int c = 0; c < 3*F && nack < 2; c++) begin
      @(negedge clk_spi);
      if (ack != '0) begin
        nack++;
        req_data[16*grant_id +: 16] = 16'($urandom);
        if (nack == 2) begin
          nvec++;
`ifdef DA_SCHED_RR_EN
          if (grant_id !== 2'd1) begin
`else
          if (grant_id !== 2'd0) begin
`endif
            nerr++;
            $display("FAIL mid_second_grant: got %0d", grant_id);
          end
        end
      end
    end
    repeat (5) @(negedge clk_spi);
    #3 rst_n = 1'b0;
    #1;
    nvec++;
    if ({ack, da_start, da_data, grant_id, busy} !== 24'h0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL mid_async_reset: ack=%b st=%b data=%h gid=%0d busy=%b, want all zero", ack, da_start, da_data, grant_id, busy);
    end
    @(negedge clk_spi);
    rst_n = 1'b1;
    @(negedge clk_spi);
    nvec++;
    if (ack !== 4'b0001 || grant_id !== 2'd0 || da_data !== req_data[15:0]) begin
      nerr++;
      $display("FAIL mid_first_grant: ack=%b gid=%0d data=%h, want 0001 0 %h", ack, grant_id, da_data, req_data[15:0]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 900; c++) begin
      @(negedge clk_spi);
      nvec++;
      if ({ack, da_start, da_data, grant_id, busy} !== {exp_ack, exp_st, exp_data, exp_gid, exp_busy}) begin
        nerr++;
        $display("FAIL random cyc %0d: {ack,st,data,gid,busy} got %h want %h", cyc,
                 {ack, da_start, da_data, grant_id, busy}, {exp_ack, exp_st, exp_data, exp_gid, exp_busy});
      end
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i]) begin
          req[i] = 1'($urandom);
          req_data[16*i +: 16] = 16'($urandom);
        end else if (!req[i] && $urandom_range(0, 5) == 0) begin
          req[i] = 1'b1;
          req_data[16*i +: 16] = 16'($urandom);
        end else if (req[i] && $urandom_range(0, 63) == 0) begin
          req[i] = 1'b0;
        end
      end
      sched_en = ($urandom_range(0, 15) != 0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_all();
    test_sched_en();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
